mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Load/store memory controller sitting between the EX stage memory-request outputs and the external data bus. It accepts one request per transaction from EX: valid, write, sign, size, address and write data. It runs a req/ack handshake on a 32-bit word bus with byte enables, holds the pipeline with a stall while the access is in flight, and returns ARMv4-formatted read data to the WB stage. Bus accesses that are not acknowledged within a bounded number of cycles are terminated with a data-abort pulse.

## Interface
- TIMEOUT, default 255: maximum number of cycles in REQ without i_bus_ack before abort; minimum 1.
- i_clk  in  1  single clock; all state changes on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_memctrl_vld  in  1  request valid from EX.
- i_memctrl_wr  in  1  1 = store, 0 = load.
- i_memctrl_sign  in  1  load result is sign-extended (byte/halfword only).
- i_memctrl_size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- i_memctrl_addr  in  32  byte address.
- i_memctrl_wdata  in  32  store data; the value sits in the low bits.
- o_stall  out  1  pipeline hold.
- o_bus_req  out  1  bus request.
- o_bus_wr  out  1  bus write.
- o_bus_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- o_bus_be  out  4  byte enables.
- o_bus_wdata  out  32  lane-replicated store data.
- i_bus_ack  in  1  bus completion; a single-cycle pulse.
- i_bus_rdata  in  32  read word, valid when i_bus_ack=1.
- o_rdata_vld  out  1  one-cycle pulse: formatted load data valid.
- o_rdata  out  32  formatted load data for WB.
- o_abort  out  1  one-cycle data-abort pulse on timeout.

## Operation
- FSM states:
  - IDLE: if i_memctrl_vld, latch the full request, clear the timeout counter, and go to REQ.
  - REQ: o_bus_req=1, driven from the latched request. On i_bus_ack go to IDLE. If the counter reaches TIMEOUT without an ack, pulse o_abort and go to IDLE.
- o_stall = (IDLE & i_memctrl_vld) | REQ. This is combinational. EX must hold its request stable while o_stall=1; the controller uses only the value latched in IDLE.
- Byte enables:
  - byte: be = 1 << addr[1:0].
  - halfword: be = addr[1] ? 1100 : 0011; addr[0] is ignored.
  - word: be = 1111.
- Store data:
  - byte: wdata[7:0] replicated four times.
  - halfword: wdata[15:0] replicated twice.
  - word: wdata unchanged. An unaligned word store writes at the aligned address with no rotation.
- Load formatting, applied to rdata captured on ack:
  - word: rotate right by 8*addr[1:0]; the ARMv4 unaligned-LDR rule.
  - halfword: select the half by addr[1], then zero- or sign-extend from bit 15.
  - byte: select the lane by addr[1:0], then zero- or sign-extend from bit 7.
  - sign is ignored for word accesses.
- Stores never assert o_rdata_vld. An aborted load asserts only o_abort, and o_rdata keeps its previous value.
- i_bus_ack while in IDLE is ignored.

## Timing
- Reset values: all outputs 0, FSM in IDLE, counter 0, latched request cleared.
- Cycle 0: i_memctrl_vld is seen in IDLE, and o_stall=1 in that cycle.
- Cycle 1: REQ, with o_bus_req/addr/be/wdata/wr valid.
- Ack in cycle N≥1 gives:
  - o_rdata_vld=1 (loads) in cycle N+1, with o_rdata registered.
  - FSM in IDLE in cycle N+1.
  - o_stall=0 in cycle N+1, unless a new request arrives in that cycle.
- Minimum load latency is 2 cycles from request to data. Back-to-back requests give at most one transaction per 2 cycles.
- Bus outputs stay constant for the whole REQ interval.
- Timeout: o_abort pulses in the cycle after the TIMEOUT-th REQ cycle without an ack, and the FSM is in IDLE that same cycle.
- An ack in the cycle the count reaches TIMEOUT wins; no abort is raised.
- Reset during REQ: o_bus_req=0 on the next edge. No rdata_vld or abort is produced for the dropped access. A late ack arriving after reset is ignored.
- The counter is wide enough for TIMEOUT, i.e. $clog2(TIMEOUT+1) bits, and saturates; it never wraps.

## Structure
- Shared package or def.v holds:
  - size encodings MEM_SIZE_BYTE/HALF/WORD;
  - FSM state encodings ST_IDLE/ST_REQ.
- One sub-module, mem_load_fmt: a purely combinational formatter taking (rdata, addr[1:0], size, sign) and producing formatted data. It is reusable by the LDM/SWP paths.
- The lane-replication and byte-enable logic stays inline.

## Test plan
- Byte load: addr 0x1003, sign=1, rdata 0x80FF_1234 → be=1000, o_rdata=0xFFFF_FF80 one cycle after ack. Repeat with sign=0 → 0x0000_0080.
- Halfword store: addr 0x2002, wdata 0x0000_BEEF → bus_addr 0x2000, be=1100, bus_wdata 0xBEEF_BEEF, wr=1, no rdata_vld.
- Unaligned word load: addr 0x3001, rdata 0x4433_2211 → o_rdata 0x1144_3322.
- Wait states: ack delayed 5 cycles → bus outputs constant, o_stall high throughout, single rdata_vld pulse. Back-to-back second request accepted in the cycle after ack.
- Timeout with TIMEOUT=4 and no ack → o_abort single pulse, FSM in IDLE, o_rdata_vld never asserted. Separately, ack exactly at the 4th REQ cycle → no abort.
- Reset asserted mid-REQ, then ack pulsed afterwards → o_bus_req=0 after the edge, all outputs 0, ack ignored.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the load/store memory controller: access sizes, FSM states
// and the request fields latched at acceptance.
package mem_ctrl_pkg;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    // Fields needed after acceptance to format the returned load data
    typedef struct packed {
        logic       sign;
        logic [1:0] size;
        logic [1:0] addr_lo;
    } mem_req_t;

endpackage

// File: rtl/mem_load_fmt.sv
// Combinational ARMv4 load formatter: lane select, sign/zero extension and the
// unaligned-LDR rotation. Shared with the LDM/SWP paths.
module mem_load_fmt
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] data
);

    logic [7:0]  lane;
    logic [15:0] half;
    logic [31:0] rot;

    always_comb begin
        lane = rdata[7:0];
        rot  = rdata;
        data = rdata;
        half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (addr_lo)
            2'd0: begin lane = rdata[7:0];   rot = rdata;                         end
            2'd1: begin lane = rdata[15:8];  rot = {rdata[7:0],  rdata[31:8]};   end
            2'd2: begin lane = rdata[23:16]; rot = {rdata[15:0], rdata[31:16]};  end
            2'd3: begin lane = rdata[31:24]; rot = {rdata[23:0], rdata[31:24]};  end
            default: ;
        endcase

        // Sign only matters for sub-word loads; word loads rotate instead
        case (size)
            MEM_SIZE_BYTE:        data = {{24{sign & lane[7]}}, lane};
            MEM_SIZE_HALF:        data = {{16{sign & half[15]}}, half};
            MEM_SIZE_WORD, 2'b11: data = rot;
            default:              data = rot;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Load/store controller: latches one EX request, runs a req/ack word-bus access with
// byte enables and a saturating timeout, and returns formatted load data to WB.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a request from EX; bus ack ignored
// ST_REQ  | bus request driven from latched request; waiting for ack
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
)
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_memctrl_vld,
    input  logic        i_memctrl_wr,
    input  logic        i_memctrl_sign,
    input  logic [1:0]  i_memctrl_size,
    input  logic [31:0] i_memctrl_addr,
    input  logic [31:0] i_memctrl_wdata,
    output logic        o_stall,
    output logic        o_bus_req,
    output logic        o_bus_wr,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
    output logic        o_rdata_vld,
    output logic [31:0] o_rdata,
    output logic        o_abort
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    mem_req_t         req;
    logic [3:0]       be_next;
    logic [31:0]      wdata_next;
    logic [31:0]      fmt_data;

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = i_memctrl_wdata;
        case (i_memctrl_size)
            MEM_SIZE_BYTE: begin
                be_next    = 4'b0001 << i_memctrl_addr[1:0];
                wdata_next = {4{i_memctrl_wdata[7:0]}};
            end
            MEM_SIZE_HALF: begin
                be_next    = i_memctrl_addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{i_memctrl_wdata[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = i_memctrl_wdata;
            end
        endcase
    end

    mem_load_fmt u_load_fmt (
        .rdata   (i_bus_rdata),
        .addr_lo (req.addr_lo),
        .size    (req.size),
        .sign    (req.sign),
        .data    (fmt_data)
    );

    assign o_bus_req = (state == ST_REQ);
    assign o_stall   = ((state == ST_IDLE) & i_memctrl_vld) | (state == ST_REQ);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            req         <= '0;
            o_bus_wr    <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_be    <= '0;
            o_bus_wdata <= '0;
            o_rdata_vld <= 1'b0;
            o_rdata     <= '0;
            o_abort     <= 1'b0;
        end else begin
            o_rdata_vld <= 1'b0;
            o_abort     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_memctrl_vld) begin
                        req.sign    <= i_memctrl_sign;
                        req.size    <= i_memctrl_size;
                        req.addr_lo <= i_memctrl_addr[1:0];
                        o_bus_wr    <= i_memctrl_wr;
                        o_bus_addr  <= {i_memctrl_addr[31:2], 2'b00};
                        o_bus_be    <= be_next;
                        o_bus_wdata <= wdata_next;
                        cnt         <= '0;
                        state       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // An ack in the final allowed cycle takes priority over the abort
                    if (i_bus_ack) begin
                        state <= ST_IDLE;
                        if (!o_bus_wr) begin
                            o_rdata_vld <= 1'b1;
                            o_rdata     <= fmt_data;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        o_abort <= 1'b1;
                        state   <= ST_IDLE;
                    end else if (cnt != CNT_W'(TIMEOUT)) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a vector table of single transactions plus hand-written
// wait-state, back-to-back, timeout and reset sequences.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld = 1'b0;
    logic        wr = 1'b0;
    logic        sign = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    logic        stall, bus_req, bus_wr, rdata_vld, abort;
    logic [31:0] bus_addr, bus_wdata, rdata;
    logic [3:0]  bus_be;
    logic        stall_t, bus_req_t, bus_wr_t, rdata_vld_t, abort_t;
    logic [31:0] bus_addr_t, bus_wdata_t, rdata_t;
    logic [3:0]  bus_be_t;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rdata = '0;

    always #5 clk = ~clk;

    mem_ctrl u_dut (
        .i_clk(clk), .i_rst(rst), .i_memctrl_vld(vld), .i_memctrl_wr(wr),
        .i_memctrl_sign(sign), .i_memctrl_size(size), .i_memctrl_addr(addr),
        .i_memctrl_wdata(wdata), .o_stall(stall), .o_bus_req(bus_req),
        .o_bus_wr(bus_wr), .o_bus_addr(bus_addr), .o_bus_be(bus_be),
        .o_bus_wdata(bus_wdata), .i_bus_ack(bus_ack), .i_bus_rdata(bus_rdata),
        .o_rdata_vld(rdata_vld), .o_rdata(rdata), .o_abort(abort)
    );

    mem_ctrl #(.TIMEOUT(4)) u_dut_t (
        .i_clk(clk), .i_rst(rst), .i_memctrl_vld(vld), .i_memctrl_wr(wr),
        .i_memctrl_sign(sign), .i_memctrl_size(size), .i_memctrl_addr(addr),
        .i_memctrl_wdata(wdata), .o_stall(stall_t), .o_bus_req(bus_req_t),
        .o_bus_wr(bus_wr_t), .o_bus_addr(bus_addr_t), .o_bus_be(bus_be_t),
        .o_bus_wdata(bus_wdata_t), .i_bus_ack(bus_ack), .i_bus_rdata(bus_rdata),
        .o_rdata_vld(rdata_vld_t), .o_rdata(rdata_t), .o_abort(abort_t)
    );

    typedef struct {
        string       name;
        logic        wr;
        logic        sign;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bus(input vec_t v);
        check({v.name, " bus_req"},   {31'b0, bus_req}, 32'd1);
        check({v.name, " bus_wr"},    {31'b0, bus_wr}, {31'b0, v.wr});
        check({v.name, " bus_addr"},  bus_addr, v.exp_addr);
        check({v.name, " bus_be"},    {28'b0, bus_be}, {28'b0, v.exp_be});
        check({v.name, " bus_wdata"}, bus_wdata, v.exp_wdata);
        check({v.name, " stall"},     {31'b0, stall}, 32'd1);
    endtask

    // Starts mid-cycle with the DUT idle; ends mid-cycle one cycle after the ack
    task automatic run_txn(input vec_t v, input int delay);
        vld = 1'b1; wr = v.wr; sign = v.sign; size = v.size; addr = v.addr; wdata = v.wdata;
        #1;
        check({v.name, " stall0"}, {31'b0, stall}, 32'd1);
        check({v.name, " req0"},   {31'b0, bus_req}, 32'd0);
        next_cycle();
        vld = 1'b0;
        bus_ack = (delay == 0);
        bus_rdata = (delay == 0) ? v.rdata : 32'h5A5A_5A5A;
        #1;
        check_bus(v);
        for (int k = 1; k <= delay; k++) begin
            next_cycle();
            bus_ack = (k == delay);
            bus_rdata = (k == delay) ? v.rdata : 32'h5A5A_5A5A;
            #1;
            check_bus(v);
            check({v.name, " early_vld"}, {31'b0, rdata_vld}, 32'd0);
        end
        next_cycle();
        bus_ack = 1'b0;
        #1;
        check({v.name, " rdata_vld"}, {31'b0, rdata_vld}, {31'b0, ~v.wr});
        if (!v.wr) last_rdata = v.exp_rdata;
        check({v.name, " rdata"}, rdata, last_rdata);
        check({v.name, " stall_end"}, {31'b0, stall}, 32'd0);
        check({v.name, " req_end"},   {31'b0, bus_req}, 32'd0);
        check({v.name, " abort"},     {31'b0, abort}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          name        wr   sign  size           addr          wdata         rdata         exp_addr      be       exp_wdata     exp_rdata
        vecs[0] = '{"ldrsb3",   1'b0, 1'b1, MEM_SIZE_BYTE, 32'h0000_1003, 32'h0,        32'h80FF_1234, 32'h0000_1000, 4'b1000, 32'h0,        32'hFFFF_FF80};
        vecs[1] = '{"ldrb3",    1'b0, 1'b0, MEM_SIZE_BYTE, 32'h0000_1003, 32'h0,        32'h80FF_1234, 32'h0000_1000, 4'b1000, 32'h0,        32'h0000_0080};
        vecs[2] = '{"strh2",    1'b1, 1'b0, MEM_SIZE_HALF, 32'h0000_2002, 32'h0000_BEEF, 32'h1111_1111, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 32'h0};
        vecs[3] = '{"ldr1",     1'b0, 1'b0, MEM_SIZE_WORD, 32'h0000_3001, 32'h0,        32'h4433_2211, 32'h0000_3000, 4'b1111, 32'h0,        32'h1144_3322};
        vecs[4] = '{"ldrsh2",   1'b0, 1'b1, MEM_SIZE_HALF, 32'h0000_4002, 32'h0,        32'h8001_7FFF, 32'h0000_4000, 4'b1100, 32'h0,        32'hFFFF_8001};
        vecs[5] = '{"ldrsh1",   1'b0, 1'b1, MEM_SIZE_HALF, 32'h0000_4001, 32'h0,        32'h8001_7FFF, 32'h0000_4000, 4'b0011, 32'h0,        32'h0000_7FFF};
        vecs[6] = '{"strb1",    1'b1, 1'b0, MEM_SIZE_BYTE, 32'h0000_5001, 32'h1234_56A5, 32'h0,        32'h0000_5000, 4'b0010, 32'hA5A5_A5A5, 32'h0};
        vecs[7] = '{"str3",     1'b1, 1'b0, MEM_SIZE_WORD, 32'h0000_6003, 32'hDEAD_BEEF, 32'h0,        32'h0000_6000, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        vecs[8] = '{"ldrb2",    1'b0, 1'b0, MEM_SIZE_BYTE, 32'h0000_7002, 32'h0,        32'hAABB_CCDD, 32'h0000_7000, 4'b0100, 32'h0,        32'h0000_00BB};
        vecs[9] = '{"ldr11s",   1'b0, 1'b1, 2'b11,         32'h0000_8002, 32'h0,        32'h8877_6655, 32'h0000_8000, 4'b1111, 32'h0,        32'h6655_8877};

        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
        check("rst bus_req",   {31'b0, bus_req}, 32'd0);
        check("rst stall",     {31'b0, stall}, 32'd0);
        check("rst bus_addr",  bus_addr, 32'd0);
        check("rst bus_be",    {28'b0, bus_be}, 32'd0);
        check("rst bus_wdata", bus_wdata, 32'd0);
        check("rst bus_wr",    {31'b0, bus_wr}, 32'd0);
        check("rst rdata",     rdata, 32'd0);
        check("rst rdata_vld", {31'b0, rdata_vld}, 32'd0);
        check("rst abort",     {31'b0, abort}, 32'd0);
        check("rst abort_t",   {31'b0, abort_t}, 32'd0);

        foreach (vecs[i]) run_txn(vecs[i], 0);

        // Ack delayed by five cycles, then back-to-back loads
        run_txn(vecs[3], 5);
        next_cycle();
        vld = 1'b1; wr = 1'b0; sign = 1'b0; size = MEM_SIZE_BYTE; addr = 32'h0000_C000;
        next_cycle();
        vld = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h0000_00F0;
        next_cycle();
        bus_ack = 1'b0;
        vld = 1'b1; size = MEM_SIZE_WORD; addr = 32'h0000_C004;
        #1;
        check("b2b first vld",   {31'b0, rdata_vld}, 32'd1);
        check("b2b first rdata", rdata, 32'h0000_00F0);
        check("b2b stall",       {31'b0, stall}, 32'd1);
        next_cycle();
        vld = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        #1;
        check("b2b req2",  {31'b0, bus_req}, 32'd1);
        check("b2b addr2", bus_addr, 32'h0000_C004);
        next_cycle();
        bus_ack = 1'b0;
        #1;
        check("b2b second vld",   {31'b0, rdata_vld}, 32'd1);
        check("b2b second rdata", rdata, 32'hCAFE_F00D);
        check("b2b stall_end",    {31'b0, stall}, 32'd0);
        last_rdata = 32'hCAFE_F00D;

        // Timeout with no ack on the TIMEOUT=4 instance
        vld = 1'b1; wr = 1'b0; sign = 1'b0; size = MEM_SIZE_WORD; addr = 32'h0000_A000;
        #1;
        check("to stall0", {31'b0, stall_t}, 32'd1);
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            vld = 1'b0;
            #1;
            check("to req",   {31'b0, bus_req_t}, 32'd1);
            check("to stall", {31'b0, stall_t}, 32'd1);
            check("to early abort", {31'b0, abort_t}, 32'd0);
        end
        next_cycle();
        #1;
        check("to abort",     {31'b0, abort_t}, 32'd1);
        check("to idle req",  {31'b0, bus_req_t}, 32'd0);
        check("to idle stall", {31'b0, stall_t}, 32'd0);
        check("to no vld",    {31'b0, rdata_vld_t}, 32'd0);
        check("to rdata kept", rdata_t, 32'hCAFE_F00D);
        next_cycle();
        #1;
        check("to abort single", {31'b0, abort_t}, 32'd0);
        check("to no vld2",      {31'b0, rdata_vld_t}, 32'd0);
        check("to dflt no abort", {31'b0, abort}, 32'd0);
        check("to dflt still req", {31'b0, bus_req}, 32'd1);
        bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
        next_cycle();
        bus_ack = 1'b0;
        #1;
        check("to release vld",   {31'b0, rdata_vld}, 32'd1);
        check("to release rdata", rdata, 32'h1234_5678);
        check("to late ack ign",  {31'b0, rdata_vld_t}, 32'd0);
        last_rdata = 32'h1234_5678;

        // Ack exactly in the fourth REQ cycle wins over the abort
        vld = 1'b1; wr = 1'b0; sign = 1'b1; size = MEM_SIZE_HALF; addr = 32'h0000_B002;
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            vld = 1'b0;
            bus_ack = (c == 4);
            bus_rdata = (c == 4) ? 32'h9ABC_0000 : 32'h5A5A_5A5A;
            #1;
            check("ack4 req", {31'b0, bus_req_t}, 32'd1);
        end
        next_cycle();
        bus_ack = 1'b0;
        #1;
        check("ack4 no abort", {31'b0, abort_t}, 32'd0);
        check("ack4 vld",      {31'b0, rdata_vld_t}, 32'd1);
        check("ack4 rdata",    rdata_t, 32'hFFFF_9ABC);
        check("ack4 idle",     {31'b0, bus_req_t}, 32'd0);
        next_cycle();
        #1;
        check("ack4 no abort2", {31'b0, abort_t}, 32'd0);
        last_rdata = 32'hFFFF_9ABC;

        // Reset in the middle of REQ, followed by a stray ack
        vld = 1'b1; wr = 1'b0; sign = 1'b0; size = MEM_SIZE_BYTE; addr = 32'h0000_D001;
        next_cycle();
        vld = 1'b0;
        #1;
        check("rreq req", {31'b0, bus_req}, 32'd1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        check("rreq req0",   {31'b0, bus_req}, 32'd0);
        check("rreq req0_t", {31'b0, bus_req_t}, 32'd0);
        check("rreq stall",  {31'b0, stall}, 32'd0);
        check("rreq addr",   bus_addr, 32'd0);
        check("rreq be",     {28'b0, bus_be}, 32'd0);
        check("rreq rdata",  rdata, 32'd0);
        check("rreq vld",    {31'b0, rdata_vld}, 32'd0);
        check("rreq abort",  {31'b0, abort}, 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        next_cycle();
        bus_ack = 1'b0;
        #1;
        check("rreq late vld",  {31'b0, rdata_vld}, 32'd0);
        check("rreq late req",  {31'b0, bus_req}, 32'd0);
        next_cycle();
        #1;
        check("rreq late vld2",  {31'b0, rdata_vld}, 32'd0);
        check("rreq late rdata", rdata, 32'd0);
        check("rreq late abort", {31'b0, abort}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
